// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller.
// Imported by hazard_detect and pipeline_ctrl.
package pipe_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int X0_ADDR = 0;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Stage-facing signal bundle of the pipeline controller.
// master = pipeline side, slave = controller side.
interface pipeline_ctrl_if #(
  parameter int AWIDTH    = 5,
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
);

  logic                 ctl_i_id_valid;
  logic [AWIDTH-1:0]    ctl_i_id_rs1_addr;
  logic [AWIDTH-1:0]    ctl_i_id_rs2_addr;
  logic                 ctl_i_ex_valid;
  logic                 ctl_i_ex_we_rd;
  logic                 ctl_i_ex_load;
  logic [AWIDTH-1:0]    ctl_i_ex_rd_addr;
  logic                 ctl_i_mem_valid;
  logic                 ctl_i_mem_we_rd;
  logic [AWIDTH-1:0]    ctl_i_mem_rd_addr;
  logic                 ctl_i_wb_change_pc;
  logic [PC_WIDTH-1:0]  ctl_i_wb_next_pc;
  logic                 ctl_i_ext_stall;

  logic                 ctl_o_stall_front;
  logic                 ctl_o_bubble_ex;
  logic                 ctl_o_stall_all;
  logic                 ctl_o_flush;
  logic                 ctl_o_change_pc;
  logic [PC_WIDTH-1:0]  ctl_o_next_pc;
  logic [1:0]           ctl_o_state;
  logic [CNT_WIDTH-1:0] ctl_o_stall_cnt;

  modport master (
    output ctl_i_id_valid, ctl_i_id_rs1_addr, ctl_i_id_rs2_addr,
    output ctl_i_ex_valid, ctl_i_ex_we_rd, ctl_i_ex_load,
    output ctl_i_ex_rd_addr,
    output ctl_i_mem_valid, ctl_i_mem_we_rd, ctl_i_mem_rd_addr,
    output ctl_i_wb_change_pc, ctl_i_wb_next_pc, ctl_i_ext_stall,
    input  ctl_o_stall_front, ctl_o_bubble_ex, ctl_o_stall_all,
    input  ctl_o_flush, ctl_o_change_pc, ctl_o_next_pc,
    input  ctl_o_state, ctl_o_stall_cnt
  );

  modport slave (
    input  ctl_i_id_valid, ctl_i_id_rs1_addr, ctl_i_id_rs2_addr,
    input  ctl_i_ex_valid, ctl_i_ex_we_rd, ctl_i_ex_load,
    input  ctl_i_ex_rd_addr,
    input  ctl_i_mem_valid, ctl_i_mem_we_rd, ctl_i_mem_rd_addr,
    input  ctl_i_wb_change_pc, ctl_i_wb_next_pc, ctl_i_ext_stall,
    output ctl_o_stall_front, ctl_o_bubble_ex, ctl_o_stall_all,
    output ctl_o_flush, ctl_o_change_pc, ctl_o_next_pc,
    output ctl_o_state, ctl_o_stall_cnt
  );

endinterface

// File: rtl/hazard_detect.sv
// Combinational RAW hazard detector, ID against EX/MEM producers.
// PIPE_CTRL_FORWARD_EN: only EX load-use stalls (EX/MEM forwarded).
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int AWIDTH = 5
) (
  input  logic              id_valid,
  input  logic [AWIDTH-1:0] rs1,
  input  logic [AWIDTH-1:0] rs2,
  input  logic              ex_valid,
  input  logic              ex_we,
  input  logic              ex_load,
  input  logic [AWIDTH-1:0] ex_rd,
  input  logic              mem_valid,
  input  logic              mem_we,
  input  logic [AWIDTH-1:0] mem_rd,
  output logic              hazard
);

  localparam logic [AWIDTH-1:0] X0 = AWIDTH'(X0_ADDR);

  logic ex_match;
  logic mem_match;

  assign ex_match = id_valid && ex_valid && ex_we &&
                    (ex_rd != X0) &&
                    ((ex_rd == rs1) || (ex_rd == rs2));

  assign mem_match = id_valid && mem_valid && mem_we &&
                     (mem_rd != X0) &&
                     ((mem_rd == rs1) || (mem_rd == rs2));

`ifdef PIPE_CTRL_FORWARD_EN
  logic unused_mem;
  assign unused_mem = mem_match;
  assign hazard     = ex_match && ex_load;
`else
  assign hazard = ex_match || mem_match;
`endif

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: hazard stall, timed redirect flush, mem-wait hold.
// Build option: PIPE_CTRL_FORWARD_EN (see hazard_detect).
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int AWIDTH       = 5,
  parameter int PC_WIDTH     = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input logic            ctl_clk,
  input logic            ctl_rst,
  pipeline_ctrl_if.slave ctl
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCW-1:0] FC_LOAD = FCW'(FLUSH_CYCLES - 1);

  state_e               state_q, state_d;
  logic                 flush_q, flush_d;
  logic                 chg_q, chg_d;
  logic [PC_WIDTH-1:0]  next_pc_q, next_pc_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [FCW-1:0]       flush_cnt_q, flush_cnt_d;
  logic                 hazard;
  logic                 stall_front;

  hazard_detect #(.AWIDTH(AWIDTH)) u_hazard (
    .id_valid (ctl.ctl_i_id_valid),
    .rs1      (ctl.ctl_i_id_rs1_addr),
    .rs2      (ctl.ctl_i_id_rs2_addr),
    .ex_valid (ctl.ctl_i_ex_valid),
    .ex_we    (ctl.ctl_i_ex_we_rd),
    .ex_load  (ctl.ctl_i_ex_load),
    .ex_rd    (ctl.ctl_i_ex_rd_addr),
    .mem_valid(ctl.ctl_i_mem_valid),
    .mem_we   (ctl.ctl_i_mem_we_rd),
    .mem_rd   (ctl.ctl_i_mem_rd_addr),
    .hazard   (hazard)
  );

  // A redirect in the same cycle wins over the hazard: no bubble.
  assign stall_front = (state_q == RUN) && hazard &&
                       !ctl.ctl_i_wb_change_pc;

  assign ctl.ctl_o_stall_front = stall_front;
  assign ctl.ctl_o_bubble_ex   = stall_front;
  assign ctl.ctl_o_stall_all   = ctl.ctl_i_ext_stall ||
                                 (state_q == HOLD);
  assign ctl.ctl_o_flush       = flush_q;
  assign ctl.ctl_o_change_pc   = chg_q;
  assign ctl.ctl_o_next_pc     = next_pc_q;
  assign ctl.ctl_o_state       = state_q;
  assign ctl.ctl_o_stall_cnt   = stall_cnt_q;

  always_comb begin
    state_d     = state_q;
    flush_d     = flush_q;
    chg_d       = 1'b0;
    next_pc_d   = next_pc_q;
    flush_cnt_d = flush_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (stall_front && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (ctl.ctl_i_wb_change_pc) begin
      state_d     = FLUSH;
      flush_d     = 1'b1;
      chg_d       = 1'b1;
      next_pc_d   = ctl.ctl_i_wb_next_pc;
      flush_cnt_d = FC_LOAD;
    end else begin
      case (state_q)
        RUN: begin
          if (ctl.ctl_i_ext_stall) state_d = HOLD;
        end
        FLUSH: begin
          if (!ctl.ctl_i_ext_stall) begin
            if (flush_cnt_q == '0) begin
              state_d = RUN;
              flush_d = 1'b0;
            end else begin
              flush_cnt_d = flush_cnt_q - 1'b1;
            end
          end
        end
        HOLD: begin
          if (!ctl.ctl_i_ext_stall) state_d = RUN;
        end
        default: begin
          state_d = RUN;
          flush_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge ctl_clk) begin
    if (ctl_rst) begin
      state_q     <= RUN;
      flush_q     <= 1'b0;
      chg_q       <= 1'b0;
      next_pc_q   <= '0;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_q     <= flush_d;
      chg_q       <= chg_d;
      next_pc_q   <= next_pc_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central pipeline controller for the 5-stage core (IF, ID, EX, MEM, WB). It detects read-after-write hazards between ID and the later stages and stalls the front end when needed. It turns a WB-stage PC redirect into a timed, multi-cycle flush and forwards the redirect target to fetch. It also freezes the whole pipeline on an external memory wait and counts stall cycles. Every stage's stall, flush and ce handshake is driven from this block.

## Interface
Parameters:
- AWIDTH, 5, register address width
- PC_WIDTH, 32, program counter width
- FLUSH_CYCLES, 2, cycles `ctl_o_flush` stays asserted after a redirect (≥1)
- CNT_WIDTH, 16, stall performance counter width

Ports:
- ctl_clk  in  1  clock
- ctl_rst  in  1  synchronous, active-high reset
- ctl_i_id_valid  in  1  ID holds a valid instruction
- ctl_i_id_rs1_addr, ctl_i_id_rs2_addr  in  AWIDTH  ID source registers
- ctl_i_ex_valid, ctl_i_ex_we_rd, ctl_i_ex_load  in  1  EX valid, writes rd, is a load
- ctl_i_ex_rd_addr  in  AWIDTH  EX destination
- ctl_i_mem_valid, ctl_i_mem_we_rd  in  1  MEM valid, writes rd
- ctl_i_mem_rd_addr  in  AWIDTH  MEM destination
- ctl_i_wb_change_pc  in  1  WB requests a redirect
- ctl_i_wb_next_pc  in  PC_WIDTH  redirect target
- ctl_i_ext_stall  in  1  data memory wait
- ctl_o_stall_front  out  1  hold IF and ID
- ctl_o_bubble_ex  out  1  load a bubble into EX (ce=0)
- ctl_o_stall_all  out  1  freeze every stage
- ctl_o_flush  out  1  flush IF, ID, EX and MEM
- ctl_o_change_pc  out  1  one-cycle redirect strobe to fetch
- ctl_o_next_pc  out  PC_WIDTH  redirect target, registered
- ctl_o_state  out  2  FSM state: RUN=0, FLUSH=1, HOLD=2
- ctl_o_stall_cnt  out  CNT_WIDTH  saturating count of cycles with stall_front=1

## Operation
- Hazard match: ID valid, a producer stage valid, producer we_rd=1, producer rd≠0, and producer rd equals rs1 or rs2.
- The load-use hazard is an EX producer match with ctl_i_ex_load=1.
- FSM, evaluated in priority order:
  - ctl_rst: go to RUN.
  - ctl_i_wb_change_pc: go to FLUSH from any state.
  - ext_stall: go to HOLD from RUN.
  - Otherwise stay.
- RUN: if a hazard is detected, stall_front=1 and bubble_ex=1 in the same cycle (combinational). The stall repeats every cycle the hazard persists.
- FLUSH, on entry (registered on the transition edge):
  - flush=1
  - change_pc=1 for exactly one cycle
  - next_pc=ctl_i_wb_next_pc
  - flush_cnt=FLUSH_CYCLES−1
- FLUSH, while resident:
  - flush_cnt decrements each cycle when ext_stall=0 and holds when ext_stall=1.
  - Exit to RUN the cycle after flush_cnt reaches 0 with ext_stall=0, so flush stays high for exactly FLUSH_CYCLES unstalled cycles.
  - Hazard outputs are forced to 0.
- FLUSH re-entry: a new change_pc while in FLUSH reloads flush_cnt, re-strobes change_pc and captures the new target.
- HOLD:
  - stall_all=1; hazard outputs forced to 0.
  - Return to RUN in the cycle after ext_stall deasserts.
- stall_all is also combinationally 1 whenever ext_stall=1, in any state.
- stall_cnt increments on each cycle with stall_front=1 and saturates at all-ones.
- The register file is write-first, so WB is never a hazard producer.

## Timing
- Reset values: state=RUN, flush=0, change_pc=0, next_pc=0, stall_cnt=0, flush_cnt=0. stall_front, bubble_ex and stall_all are 0 while inputs are idle.
- Hazard to stall_front/bubble_ex: 0 cycles (combinational).
- change_pc input to ctl_o_flush/ctl_o_change_pc/ctl_o_next_pc: 1 cycle (registered).
- A simultaneous hazard and change_pc resolves to FLUSH: no bubble, and stall_cnt does not increment.
- Reset mid-FLUSH or mid-HOLD returns every register to its reset value on the next edge.

## Configuration
- PIPE_CTRL_FORWARD_EN defined: the datapath forwards from EX and MEM, so only the EX load-use match causes a stall.
- PIPE_CTRL_FORWARD_EN undefined: any EX or MEM producer match stalls, loads or not.

## Structure
- Package pipe_ctrl_pkg holds:
  - state encodings RUN/FLUSH/HOLD
  - the FSM width constant
  - the x0 address constant
- Sub-module hazard_detect (purely combinational) contains the match logic and the PIPE_CTRL_FORWARD_EN selection. It outputs a single `hazard` bit.

## Test plan
- EX load writing rd=5, ID reads rs1=5 -> stall_front=1 and bubble_ex=1 for one cycle; stall_cnt goes 0→1.
- EX ALU op writing rd=7, ID reads rs2=7 -> no stall with FORWARD_EN, stall_front=1 without it.
- EX load with rd=0, ID rs1=0 -> no stall in either build.
- change_pc=1 with next_pc=0x100, FLUSH_CYCLES=2 -> next cycle: change_pc=1 for 1 cycle, next_pc=0x100. Flush is high for 2 cycles, then state=RUN.
- During FLUSH, ext_stall held 3 cycles -> flush extends to 5 cycles total and stall_all=1 for those 3 cycles.
- Force 2^16+3 hazard cycles -> stall_cnt=0xFFFF. Assert ctl_rst mid-HOLD -> state=RUN and all registered outputs 0 after one edge.
